// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor assembled from two half-subtractor cells and an OR;
// purely combinational.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1_s;
  logic bo1_s;
  logic bo2_s;

  half_subtractor u_hs_ab (
    .a    (a),
    .b    (b),
    .d    (d1_s),
    .bout (bo1_s)
  );

  // Second stage folds in the incoming borrow.
  half_subtractor u_hs_bin (
    .a    (d1_s),
    .b    (bin),
    .d    (d),
    .bout (bo2_s)
  );

  assign bout = bo1_s | bo2_s;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, one bit per cycle LSB first,
// with a start/done handshake and a held result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bor
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bor_q, bor_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               bit_d_s;
  logic               bit_bo_s;

  full_subtractor_bit u_fsb (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (bit_d_s),
    .bout (bit_bo_s)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    diff_d   = diff_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          d_d      = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        d_d      = {bit_d_s, d_q[WIDTH-1:1]};
        borrow_d = bit_bo_s;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last bit: publish the fully shifted difference and final borrow.
        if (cnt_q == CNT_LAST) begin
          diff_d  = {bit_d_s, d_q[WIDTH-1:1]};
          bor_d   = bit_bo_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      diff_q   <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      diff_q   <= diff_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Diff = diff_q;
  assign Bor  = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed handshake/latency cases
// plus a randomized sweep against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bor;

  int n_asserts = 0;
  int n_fails   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bor   (Bor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {borrow, diff} from plain (W+1)-bit subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Called just after the accepting edge; counts busy samples and edges to done.
  task automatic wait_done(input int budget, output int edges, output int busy_cnt, output bit timed_out);
    edges = 0;
    busy_cnt = 0;
    timed_out = 1'b0;
    forever begin
      if (busy) busy_cnt++;
      if (done) break;
      if (edges >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W:0] r;
    int edges, bc;
    bit to;
    r = ref_sub(a, b);
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = W'($urandom); B = W'($urandom);
    wait_done(4 * W, edges, bc, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_latency"}, 32'(edges), 32'(W));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(W));
    check({tag, "_diff"}, 32'(Diff), 32'(r[W-1:0]));
    check({tag, "_bor"}, 32'(Bor), 32'(r[W]));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int edges, bc, ndone;
    bit to;
    logic [W-1:0] d_seen;
    logic b_seen;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_bor", 32'(Bor), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(8'h35, 8'h12, "op35_12");
    do_op(8'h12, 8'h35, "op12_35");
    do_op(8'h00, 8'h01, "op00_01");
    do_op(8'hFF, 8'hFF, "opFF_FF");
    do_op(8'h00, 8'hFF, "op00_FF");

    // Start pulses and operand changes during RUN are ignored.
    @(negedge clk); start = 1'b1; A = 8'h35; B = 8'h12;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b1; A = 8'hAA; B = 8'h55;
      @(negedge clk); start = 1'b0;
    end
    ndone = 0; d_seen = '0; b_seen = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        d_seen = Diff;
        b_seen = Bor;
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_diff", 32'(d_seen), 32'h23);
    check("ign_bor", 32'(b_seen), 32'd0);

    // Back-to-back: start held high through DONE with new operands.
    @(negedge clk); start = 1'b1; A = 8'h35; B = 8'h12;
    @(posedge clk); #1; A = 8'h80; B = 8'h01;
    wait_done(4 * W, edges, bc, to);
    check("b2b_first_timeout", 32'(to), 32'd0);
    check("b2b_first_diff", 32'(Diff), 32'h23);
    check("b2b_first_bor", 32'(Bor), 32'd0);
    @(posedge clk); #1;
    check("b2b_no_idle", 32'(busy), 32'd1);
    check("b2b_diff_held", 32'(Diff), 32'h23);
    @(negedge clk); start = 1'b0;
    wait_done(4 * W, edges, bc, to);
    check("b2b_second_timeout", 32'(to), 32'd0);
    check("b2b_second_latency", 32'(edges), 32'(W));
    check("b2b_second_diff", 32'(Diff), 32'h7F);
    check("b2b_second_bor", 32'(Bor), 32'd0);
    @(posedge clk); #1;
    check("b2b_idle_after", 32'(busy | done), 32'd0);

    // Reset mid-operation (after four bits processed) discards everything.
    @(negedge clk); start = 1'b1; A = 8'h35; B = 8'h12;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(Diff), 32'd0);
    check("mid_rst_bor", 32'(Bor), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_still_idle", 32'(busy | done), 32'd0);
    do_op(8'h00, 8'hFF, "post_rst");

    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
